sum_channel_scheduler: RTL and testbench



---
 rtl/sum_channel_scheduler.sv | 158 +++++++++++++++
 tb/tb_sum_channel_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sum_channel_scheduler.sv
// Purpose : round-robin time-share of one signed 3-operand summer (IN1+IN2+IN3) among N_CH requesters.
// Latency : grant edge k -> OUT/OUT_VALID/ACK high in cycle k+3; one result every 3 cycles under load.
// Backpressure: level REQ held until ACK; no output stall, the result strobe is never held off.
// Ports   : CLK, RST (async, active-high); REQ[N_CH]; IN1/IN2/IN3_BUS[16*N_CH] (ch i at [16i+15:16i]);
//           ACK[N_CH] pulse; OUT signed result (held); OUT_CH tag; OUT_VALID strobe; BUSY.
module sum_channel_scheduler #(
    parameter int N_CH     = 4,
    parameter int CW       = 2,
    parameter bit SATURATE = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [N_CH-1:0]        REQ,
    input  logic [16*N_CH-1:0]     IN1_BUS,
    input  logic [16*N_CH-1:0]     IN2_BUS,
    input  logic [16*N_CH-1:0]     IN3_BUS,
    output logic [N_CH-1:0]        ACK,
    output logic signed [15:0]     OUT,
    output logic [CW-1:0]          OUT_CH,
    output logic                   OUT_VALID,
    output logic                   BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM1 = 2'd1,
        SUM2 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [CW-1:0]         r_last;
    logic [CW-1:0]         r_gch;
    logic signed [15:0]    r_a;
    logic signed [15:0]    r_b;
    logic signed [15:0]    r_c;
    logic signed [17:0]    r_t;
    logic [N_CH-1:0]       r_ack;
    logic signed [15:0]    r_out;
    logic [CW-1:0]         r_out_ch;
    logic                  r_out_vld;
    logic                  r_busy;

    logic [N_CH-1:0]       w_elig;
    logic                  w_found;
    logic                  w_hi_found;
    logic [CW-1:0]         w_hi;
    logic [CW-1:0]         w_lo;
    logic [CW-1:0]         w_gnt;
    logic signed [17:0]    w_s;
    logic signed [15:0]    w_res;

    // Round-robin pick: lowest eligible channel above r_last wins; if none,
    // wrap to the lowest eligible channel overall. The channel being
    // acknowledged this cycle is masked so a still-high REQ is not re-granted.
    always_comb begin
        w_elig     = REQ & ~r_ack;
        w_found    = |w_elig;
        w_hi_found = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (w_elig[j]) begin
                w_lo = CW'(j);
                if (j > int'(r_last)) begin
                    w_hi_found = 1'b1;
                    w_hi       = CW'(j);
                end
            end
        end
        w_gnt = w_hi_found ? w_hi : w_lo;
    end

    // Second adder stage and output shaping. 18 bits hold the full
    // three-operand range, so the clamp decision is exact.
    always_comb begin
        w_s = r_t + {{2{r_c[15]}}, r_c};
        if (SATURATE) begin
            if (w_s > 18'sd32767) begin
                w_res = 16'sh7FFF;
            end else if (w_s < -18'sd32768) begin
                w_res = 16'sh8000;
            end else begin
                w_res = w_s[15:0];
            end
        end else begin
            w_res = w_s[15:0];
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_found ? SUM1 : IDLE;
            SUM1:    w_next = SUM2;
            SUM2:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_last    <= CW'(N_CH - 1);
            r_gch     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_t       <= '0;
            r_ack     <= '0;
            r_out     <= '0;
            r_out_ch  <= '0;
            r_out_vld <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_out_vld <= 1'b0;
            r_busy    <= (w_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_a   <= IN1_BUS[16*w_gnt +: 16];
                        r_b   <= IN2_BUS[16*w_gnt +: 16];
                        r_c   <= IN3_BUS[16*w_gnt +: 16];
                        r_gch <= w_gnt;
                    end
                end
                SUM1: begin
                    r_t <= {{2{r_a[15]}}, r_a} + {{2{r_b[15]}}, r_b};
                end
                SUM2: begin
                    r_out     <= w_res;
                    r_out_ch  <= r_gch;
                    r_out_vld <= 1'b1;
                    r_ack     <= N_CH'(1) << r_gch;
                    r_last    <= r_gch;
                end
                default: begin
                end
            endcase
        end
    end

    assign ACK       = r_ack;
    assign OUT       = r_out;
    assign OUT_CH    = r_out_ch;
    assign OUT_VALID = r_out_vld;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_sum_channel_scheduler.sv
// Purpose : self-checking bench for sum_channel_scheduler; saturating and wrapping instances share stimulus.
// Latency : expects strobe 3 cycles after the grant edge and 3-cycle spacing under continuous load.
// Backpressure: requesters hold REQ until their ACK is observed, then drop it.
module tb_sum_channel_scheduler;

    localparam int N_CH = 4;
    localparam int CW   = 2;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [N_CH-1:0]       REQ;
    logic [16*N_CH-1:0]    in1_bus;
    logic [16*N_CH-1:0]    in2_bus;
    logic [16*N_CH-1:0]    in3_bus;

    logic [N_CH-1:0]       ack_s,   ack_w;
    logic signed [15:0]    out_s,   out_w;
    logic [CW-1:0]         out_ch_s, out_ch_w;
    logic                  vld_s,   vld_w;
    logic                  busy_s,  busy_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    sum_channel_scheduler #(.N_CH(N_CH), .CW(CW), .SATURATE(1'b1)) u_sat (
        .CLK(CLK), .RST(RST), .REQ(REQ),
        .IN1_BUS(in1_bus), .IN2_BUS(in2_bus), .IN3_BUS(in3_bus),
        .ACK(ack_s), .OUT(out_s), .OUT_CH(out_ch_s), .OUT_VALID(vld_s), .BUSY(busy_s)
    );

    sum_channel_scheduler #(.N_CH(N_CH), .CW(CW), .SATURATE(1'b0)) u_wrap (
        .CLK(CLK), .RST(RST), .REQ(REQ),
        .IN1_BUS(in1_bus), .IN2_BUS(in2_bus), .IN3_BUS(in3_bus),
        .ACK(ack_w), .OUT(out_w), .OUT_CH(out_ch_w), .OUT_VALID(vld_w), .BUSY(busy_w)
    );

    typedef struct {
        int ch;
        int a;
        int b;
        int c;
        int exp_sat;
        int exp_wrap;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_ops(input int ch, input int a, input int b, input int c);
        in1_bus[16*ch +: 16] = 16'(a);
        in2_bus[16*ch +: 16] = 16'(b);
        in3_bus[16*ch +: 16] = 16'(c);
    endtask

    // Called right after a grant edge; counts negedges until the strobe.
    task automatic wait_strobe(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (busy_s) busy_cnt++;
            if (vld_s) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int bcnt;
        int k;
        int cyc;
        int last_cyc;
        int exp_ch;

        vecs[0] = '{2,    100,    200,    300,    600,    600};
        vecs[1] = '{0,  30000,  30000,  30000,  32767,  24464};
        vecs[2] = '{1, -30000, -30000, -30000, -32768, -24464};
        vecs[3] = '{1,     -1,     -1,     -1,     -3,     -3};
        vecs[4] = '{3,  32767,  32767,  32767,  32767,  32765};
        vecs[5] = '{0, -32768, -32768, -32768, -32768, -32768};
        vecs[6] = '{3,      1,     -1,      0,      0,      0};

        RST     = 1'b1;
        REQ     = '0;
        in1_bus = '0;
        in2_bus = '0;
        in3_bus = '0;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_out",    int'(out_s), 0);
        chk("rst_out_ch", int'(out_ch_s), 0);
        chk("rst_valid",  int'(vld_s), 0);
        chk("rst_ack",    int'(ack_s), 0);
        chk("rst_busy",   int'(busy_s), 0);
        RST = 1'b0;
        @(negedge CLK);

        // Single-channel vectors
        for (int i = 0; i < 7; i++) begin
            set_ops(vecs[i].ch, vecs[i].a, vecs[i].b, vecs[i].c);
            REQ = N_CH'(1) << vecs[i].ch;
            @(posedge CLK);
            wait_strobe(lat, bcnt);
            REQ = '0;
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_busy_cycles", i), bcnt, 2);
            chk($sformatf("v%0d_out_sat", i), int'(out_s), vecs[i].exp_sat);
            chk($sformatf("v%0d_out_wrap", i), int'(out_w), vecs[i].exp_wrap);
            chk($sformatf("v%0d_out_ch", i), int'(out_ch_s), vecs[i].ch);
            chk($sformatf("v%0d_ack", i), int'(ack_s), 1 << vecs[i].ch);
            chk($sformatf("v%0d_wrap_valid", i), int'(vld_w), 1);
            @(negedge CLK);
            chk($sformatf("v%0d_valid_drop", i), int'(vld_s), 0);
            chk($sformatf("v%0d_ack_drop", i), int'(ack_s), 0);
            chk($sformatf("v%0d_out_hold", i), int'(out_s), vecs[i].exp_sat);
        end

        // Round-robin under continuous full load, from reset priority
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < N_CH; c++) set_ops(c, c + 1, 10 * (c + 1), 100 * (c + 1));
        REQ      = 4'b1111;
        k        = 0;
        last_cyc = 0;
        for (cyc = 1; cyc <= 60 && k < 6; cyc++) begin
            @(negedge CLK);
            if (vld_s) begin
                exp_ch = k % N_CH;
                chk($sformatf("rr%0d_ch", k), int'(out_ch_s), exp_ch);
                chk($sformatf("rr%0d_out", k), int'(out_s), 111 * (exp_ch + 1));
                chk($sformatf("rr%0d_ack", k), int'(ack_s), 1 << exp_ch);
                if (k > 0) chk($sformatf("rr%0d_gap", k), cyc - last_cyc, 3);
                last_cyc = cyc;
                k++;
                if (k == 6) REQ = '0;
            end
        end
        chk("rr_strobe_count", k, 6);
        repeat (3) @(negedge CLK);
        chk("rr_idle_busy", int'(busy_s), 0);

        // Operands changed one cycle after grant must not affect the result
        set_ops(3, 1, 2, 3);
        REQ = 4'b1000;
        @(posedge CLK);
        @(negedge CLK);
        set_ops(3, 1000, 1000, 1000);
        wait_strobe(lat, bcnt);
        REQ = '0;
        chk("stab_latency", lat, 2);
        chk("stab_out", int'(out_s), 6);
        chk("stab_ch", int'(out_ch_s), 3);
        @(negedge CLK);

        // Reset abort during SUM1 of a ch2 operation
        set_ops(2, 7, 8, 9);
        set_ops(1, 5, 6, 7);
        REQ = 4'b0100;
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_busy_before", int'(busy_s), 1);
        RST = 1'b1;
        #1;
        chk("abort_out",    int'(out_s), 0);
        chk("abort_out_ch", int'(out_ch_s), 0);
        chk("abort_valid",  int'(vld_s), 0);
        chk("abort_ack",    int'(ack_s), 0);
        chk("abort_busy",   int'(busy_s), 0);
        REQ = 4'b0110;
        @(negedge CLK);
        chk("abort_ack_held", int'(ack_s), 0);
        RST = 1'b0;
        k = 0;
        for (cyc = 1; cyc <= 30 && k < 2; cyc++) begin
            @(negedge CLK);
            if (vld_s) begin
                if (k == 0) begin
                    chk("post_rst_first_ch", int'(out_ch_s), 1);
                    chk("post_rst_first_ack", int'(ack_s), 2);
                    chk("post_rst_first_out", int'(out_s), 18);
                end else begin
                    chk("post_rst_second_ch", int'(out_ch_s), 2);
                    chk("post_rst_second_out", int'(out_s), 24);
                    REQ = '0;
                end
                k++;
            end
        end
        chk("post_rst_strobe_count", k, 2);
        REQ = '0;
        repeat (2) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
